// File: rtl/lock_manager.sv
// Hardware mutex server: LOCK/UNLOCK commands in, 1-byte grant/deny reply routed back to requester.
// Latency: command accepted at edge k, reply valid after edge k+1; UNLOCK/unknown return to idle after k+1.
// Backpressure: one command in flight; inStream_TREADY low in EXEC and ACK, reply held until outStream_TREADY.
module lock_manager #(
    parameter int LOCK_ID_BITS = 4,
    parameter int ID_BITS      = 4
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [63:0]          inStream_TDATA,
    input  logic                 inStream_TVALID,
    input  logic [ID_BITS-1:0]   inStream_TID,
    output logic                 inStream_TREADY,
    output logic [7:0]           outStream_TDATA,
    output logic                 outStream_TVALID,
    input  logic                 outStream_TREADY,
    output logic [ID_BITS-1:0]   outStream_TDEST
);

    localparam int NUM_LOCKS = 2 ** LOCK_ID_BITS;

    localparam logic [7:0] OP_LOCK   = 8'h04;
    localparam logic [7:0] OP_UNLOCK = 8'h06;

    localparam logic [7:0] REPLY_GRANT = 8'h01;
    localparam logic [7:0] REPLY_DENY  = 8'h00;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    // Latched command held across the EXEC cycle.
    typedef struct packed {
        logic [7:0]              opcode;
        logic [LOCK_ID_BITS-1:0] lock_id;
        logic [ID_BITS-1:0]      tid;
    } cmd_t;

    logic [1:0]           state;
    cmd_t                 cmd;
    logic [NUM_LOCKS-1:0] locked;
    logic                 accept;
    logic                 reply_taken;
    logic                 target_busy;

    // Only the opcode byte and the lock-ID field carry meaning; the rest is ignored.
    logic unused_tdata_bits;
    assign unused_tdata_bits = ^inStream_TDATA[63:8+LOCK_ID_BITS];

    assign inStream_TREADY  = (state == ST_IDLE);
    assign outStream_TVALID = (state == ST_ACK);
    assign accept           = inStream_TVALID & inStream_TREADY;
    assign reply_taken      = outStream_TVALID & outStream_TREADY;
    assign target_busy      = locked[cmd.lock_id];

    // Command FSM, lock table and reply registers; reset drops any in-flight command.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state           <= ST_IDLE;
            cmd             <= '0;
            locked          <= '0;
            outStream_TDATA <= 8'h00;
            outStream_TDEST <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cmd.opcode  <= inStream_TDATA[7:0];
                        cmd.lock_id <= inStream_TDATA[8 +: LOCK_ID_BITS];
                        cmd.tid     <= inStream_TID;
                        state       <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cmd.opcode == OP_LOCK) begin
                        // Test-and-set: a held lock is left untouched and the requester is denied.
                        if (!target_busy) begin
                            locked[cmd.lock_id] <= 1'b1;
                            outStream_TDATA     <= REPLY_GRANT;
                        end else begin
                            outStream_TDATA     <= REPLY_DENY;
                        end
                        outStream_TDEST <= cmd.tid;
                        state           <= ST_ACK;
                    end else if (cmd.opcode == OP_UNLOCK) begin
                        // No ownership tracking: anyone may release any lock, and releasing a free one is harmless.
                        locked[cmd.lock_id] <= 1'b0;
                        state               <= ST_IDLE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_ACK: begin
                    if (reply_taken) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_manager.sv
// Directed bench for lock_manager: grant/deny, unlock, reply stall, independent locks, mid-command reset.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Reply consumer holds outStream_TREADY low except for explicit release pulses.
module tb_lock_manager;

    logic        ap_clk;
    logic        ap_rst;
    logic [63:0] in_tdata;
    logic        in_tvalid;
    logic [3:0]  in_tid;
    logic        in_tready;
    logic [7:0]  out_tdata;
    logic        out_tvalid;
    logic        out_tready;
    logic [3:0]  out_tdest;

    int n_checks;
    int n_fail;

    lock_manager #(.LOCK_ID_BITS(4), .ID_BITS(4)) dut (
        .ap_clk           (ap_clk),
        .ap_rst           (ap_rst),
        .inStream_TDATA   (in_tdata),
        .inStream_TVALID  (in_tvalid),
        .inStream_TID     (in_tid),
        .inStream_TREADY  (in_tready),
        .outStream_TDATA  (out_tdata),
        .outStream_TVALID (out_tvalid),
        .outStream_TREADY (out_tready),
        .outStream_TDEST  (out_tdest)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d required to finish", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    // Present one command for exactly one edge (DUT must be idle), leaving the DUT in EXEC.
    task automatic send_cmd(input logic [3:0] tid, input logic [63:0] data);
        in_tid    = tid;
        in_tdata  = data;
        in_tvalid = 1'b1;
        step();
        in_tvalid = 1'b0;
        in_tdata  = 64'h0;
    endtask

    // Lock command: check EXEC cycle, the reply one edge later, then release it with a one-cycle pulse.
    task automatic lock_cmd(input string tag, input logic [3:0] tid, input logic [63:0] data,
                            input logic [7:0] exp_dat);
        send_cmd(tid, data);
        check_val({tag, "_exec_in_rdy"}, {63'd0, in_tready}, 64'd0);
        check_val({tag, "_exec_out_vld"}, {63'd0, out_tvalid}, 64'd0);
        step();
        check_val({tag, "_out_vld"}, {63'd0, out_tvalid}, 64'd1);
        check_val({tag, "_out_dat"}, {56'd0, out_tdata}, {56'd0, exp_dat});
        check_val({tag, "_out_dest"}, {60'd0, out_tdest}, {60'd0, tid});
        check_val({tag, "_ack_in_rdy"}, {63'd0, in_tready}, 64'd0);
        out_tready = 1'b1;
        step();
        out_tready = 1'b0;
        check_val({tag, "_released_vld"}, {63'd0, out_tvalid}, 64'd0);
        check_val({tag, "_released_in_rdy"}, {63'd0, in_tready}, 64'd1);
    endtask

    // Non-replying command: TREADY low one cycle, then idle with no reply for several cycles.
    task automatic silent_cmd(input string tag, input logic [3:0] tid, input logic [63:0] data);
        send_cmd(tid, data);
        check_val({tag, "_exec_in_rdy"}, {63'd0, in_tready}, 64'd0);
        check_val({tag, "_vld0"}, {63'd0, out_tvalid}, 64'd0);
        step();
        check_val({tag, "_in_rdy_back"}, {63'd0, in_tready}, 64'd1);
        check_val({tag, "_vld1"}, {63'd0, out_tvalid}, 64'd0);
        step();
        check_val({tag, "_vld2"}, {63'd0, out_tvalid}, 64'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        ap_rst     = 1'b1;
        in_tdata   = 64'h0;
        in_tvalid  = 1'b0;
        in_tid     = 4'h0;
        out_tready = 1'b0;
        step();
        step();
        ap_rst = 1'b0;

        // Reset state, then two idle cycles.
        for (int i = 0; i < 3; i++) begin
            check_val("rst_in_rdy", {63'd0, in_tready}, 64'd1);
            check_val("rst_out_vld", {63'd0, out_tvalid}, 64'd0);
            check_val("rst_out_dat", {56'd0, out_tdata}, 64'd0);
            check_val("rst_out_dest", {60'd0, out_tdest}, 64'd0);
            step();
        end

        // Grant lock 0 to TID 0, then deny it to TID 1.
        lock_cmd("lock0_tid0", 4'd0, 64'h04, 8'h01);
        lock_cmd("lock0_tid1_deny", 4'd1, 64'h04, 8'h00);

        // Unlock lock 0 (no reply), then TID 15 gets it.
        silent_cmd("unlock0", 4'd0, 64'h06);
        lock_cmd("lock0_tid15", 4'd15, 64'h04, 8'h01);

        // Held reply: TID 10 denied on lock 0, consumer stalls 10 cycles.
        send_cmd(4'd10, 64'h04);
        step();
        for (int i = 0; i < 10; i++) begin
            check_val("hold_vld", {63'd0, out_tvalid}, 64'd1);
            check_val("hold_dat", {56'd0, out_tdata}, 64'h00);
            check_val("hold_dest", {60'd0, out_tdest}, 64'd10);
            check_val("hold_in_rdy", {63'd0, in_tready}, 64'd0);
            step();
        end
        out_tready = 1'b1;
        step();
        out_tready = 1'b0;
        check_val("hold_released_vld", {63'd0, out_tvalid}, 64'd0);
        check_val("hold_released_in_rdy", {63'd0, in_tready}, 64'd1);

        // Independent locks: free lock 0, then 0 and 3 both grant; 3 again denies.
        silent_cmd("unlock0_b", 4'd2, 64'h0006);
        lock_cmd("lock0_again", 4'd2, 64'h0004, 8'h01);
        lock_cmd("lock3", 4'd3, 64'h0304, 8'h01);
        lock_cmd("lock3_deny", 4'd4, 64'h0304, 8'h00);

        // Unlock of a free lock and an unknown opcode are both silent no-ops.
        silent_cmd("unlock_free5", 4'd5, 64'h0506);
        silent_cmd("bad_opcode", 4'd5, 64'h0505);
        lock_cmd("lock5_after_bad", 4'd5, 64'h0504, 8'h01);

        // Bits above the lock-ID field are ignored: this addresses lock 9.
        lock_cmd("lock9_upper_bits", 4'd6, 64'hDEAD_BEEF_0000_F904, 8'h01);
        lock_cmd("lock9_deny", 4'd7, 64'h0904, 8'h00);

        // Reset during EXEC drops the command, clears reply regs and frees all locks.
        send_cmd(4'd8, 64'h0704);
        ap_rst = 1'b1;
        step();
        ap_rst = 1'b0;
        check_val("midrst_out_vld", {63'd0, out_tvalid}, 64'd0);
        check_val("midrst_in_rdy", {63'd0, in_tready}, 64'd1);
        check_val("midrst_out_dat", {56'd0, out_tdata}, 64'd0);
        check_val("midrst_out_dest", {60'd0, out_tdest}, 64'd0);
        step();
        check_val("midrst_no_reply", {63'd0, out_tvalid}, 64'd0);
        lock_cmd("lock0_after_rst", 4'd2, 64'h0004, 8'h01);
        lock_cmd("lock3_after_rst", 4'd2, 64'h0304, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
